// File: rtl/arm_lp_pkg.sv
// Shared types and defaults for the ARM-LP stage sequencer: state encoding,
// timeout/counter widths, ALU control codes and the branch-decision helper.
package arm_lp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd6
  } seq_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEFAULT_COUNT_WIDTH    = 32;
  localparam int unsigned TIMER_WIDTH            = 8;

  localparam logic [3:0] ALU_CTRL_AND    = 4'b0000;
  localparam logic [3:0] ALU_CTRL_ORR    = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD    = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB    = 4'b0110;
  localparam logic [3:0] ALU_CTRL_PASS_B = 4'b0111;

  function automatic logic take_branch(input logic branch, input logic uncond, input logic zero);
    return uncond | (branch & zero);
  endfunction

endpackage

// File: rtl/sequencer_timeout_timer.sv
// Cache-wait watchdog: down-counter reloaded by i_clear, decremented while
// i_enable, o_expired flags the TIMEOUT_CYCLES-th consecutive wait cycle.
module sequencer_timeout_timer
  import arm_lp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic resetN,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TIMER_WIDTH-1:0] LOAD_VALUE = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= LOAD_VALUE;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Terminal count is combinational so the FSM leaves on the expiring cycle itself.
  assign o_expired = i_enable && (r_count == '0);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the ARM-LP datapath.
// Optional STALL_COUNTER_EN adds a cache-wait cycle counter on stallCount.
//
// state     | meaning
// IDLE      | stopped at an instruction boundary, waiting for run
// FETCH     | iCacheRequest held until iCacheReady (timeout -> FAULT)
// DECODE    | one cycle while the controller registers its flags
// EXECUTE   | ALU cycle, branch decision captured, route to MEMORY/WRITEBACK/retire
// MEMORY    | dCacheRequest held until dCacheReady (timeout -> FAULT)
// WRITEBACK | register file write, then retire
// FAULT     | sticky trap, left only by reset
module stage_sequencer
  import arm_lp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned COUNT_WIDTH    = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   run,
  input  logic                   iCacheReady,
  input  logic                   dCacheReady,
  input  logic                   memRead,
  input  logic                   memWrite,
  input  logic                   regWriteFlag,
  input  logic                   branch,
  input  logic                   unconditionalBranch,
  input  logic                   zeroFlag,
  output logic                   iCacheRequest,
  output logic                   instructionLatch,
  output logic                   aluEnable,
  output logic                   dCacheRequest,
  output logic                   dCacheWrite,
  output logic                   regFileWrite,
  output logic                   pcEnable,
  output logic                   pcSelectBranch,
  output logic                   busy,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] retiredCount,
  output logic [COUNT_WIDTH-1:0] stallCount
);

  seq_state_e             r_state;
  logic                   r_icache_req, r_latch, r_alu, r_dcache_req, r_dcache_write;
  logic                   r_regfile_write, r_pc_en, r_pc_sel, r_busy, r_fault, r_take_branch;
  logic [COUNT_WIDTH-1:0] r_retired;

  logic w_take_branch, w_mem_access, w_writeback, w_retire, w_retire_sel;
  logic w_timer_en, w_timer_clr, w_expired;

  assign w_take_branch = take_branch(branch, unconditionalBranch, zeroFlag);
  assign w_mem_access  = memRead | memWrite;
  assign w_writeback   = regWriteFlag & ~branch & ~unconditionalBranch;

  // Every path that ends an instruction funnels through one retire branch below.
  assign w_retire = ((r_state == ST_EXECUTE) & ~w_mem_access & ~w_writeback)
                  | ((r_state == ST_MEMORY) & dCacheReady & ~memRead)
                  | (r_state == ST_WRITEBACK);
  assign w_retire_sel = (r_state == ST_EXECUTE) ? w_take_branch : r_take_branch;

  assign w_timer_en  = ((r_state == ST_FETCH) & ~iCacheReady)
                     | ((r_state == ST_MEMORY) & ~dCacheReady);
  assign w_timer_clr = ~w_timer_en;

  sequencer_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock    (clock),
    .resetN   (resetN),
    .i_clear  (w_timer_clr),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state         <= ST_IDLE;
      r_icache_req    <= 1'b0;
      r_latch         <= 1'b0;
      r_alu           <= 1'b0;
      r_dcache_req    <= 1'b0;
      r_dcache_write  <= 1'b0;
      r_regfile_write <= 1'b0;
      r_pc_en         <= 1'b0;
      r_pc_sel        <= 1'b0;
      r_busy          <= 1'b0;
      r_fault         <= 1'b0;
      r_take_branch   <= 1'b0;
      r_retired       <= '0;
    end else begin
      r_latch         <= 1'b0;
      r_alu           <= 1'b0;
      r_regfile_write <= 1'b0;
      r_pc_en         <= 1'b0;
      r_pc_sel        <= 1'b0;
      if (w_retire) begin
        r_state        <= run ? ST_FETCH : ST_IDLE;
        r_icache_req   <= run;
        r_busy         <= run;
        r_dcache_req   <= 1'b0;
        r_dcache_write <= 1'b0;
        r_pc_en        <= 1'b1;
        r_pc_sel       <= w_retire_sel;
        r_retired      <= r_retired + 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (run) begin
              r_state      <= ST_FETCH;
              r_icache_req <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (iCacheReady) begin
              r_state      <= ST_DECODE;
              r_icache_req <= 1'b0;
              r_latch      <= 1'b1;
            end else if (w_expired) begin
              r_state      <= ST_FAULT;
              r_icache_req <= 1'b0;
              r_busy       <= 1'b0;
              r_fault      <= 1'b1;
            end
          end
          ST_DECODE: begin
            r_state <= ST_EXECUTE;
            r_alu   <= 1'b1;
          end
          ST_EXECUTE: begin
            r_take_branch <= w_take_branch;
            if (memRead & memWrite) begin
              r_state <= ST_FAULT;
              r_busy  <= 1'b0;
              r_fault <= 1'b1;
            end else if (w_mem_access) begin
              r_state        <= ST_MEMORY;
              r_dcache_req   <= 1'b1;
              r_dcache_write <= memWrite;
            end else begin
              r_state         <= ST_WRITEBACK;
              r_regfile_write <= 1'b1;
            end
          end
          ST_MEMORY: begin
            if (dCacheReady) begin
              r_state         <= ST_WRITEBACK;
              r_dcache_req    <= 1'b0;
              r_dcache_write  <= 1'b0;
              r_regfile_write <= 1'b1;
            end else if (w_expired) begin
              r_state        <= ST_FAULT;
              r_dcache_req   <= 1'b0;
              r_dcache_write <= 1'b0;
              r_busy         <= 1'b0;
              r_fault        <= 1'b1;
            end else begin
              r_dcache_write <= memWrite;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef STALL_COUNTER_EN
  logic [COUNT_WIDTH-1:0] r_stall_count;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_stall_count <= '0;
    end else if (w_timer_en) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stallCount = r_stall_count;
`else
  assign stallCount = '0;
`endif

  assign iCacheRequest    = r_icache_req;
  assign instructionLatch = r_latch;
  assign aluEnable        = r_alu;
  assign dCacheRequest    = r_dcache_req;
  assign dCacheWrite      = r_dcache_write;
  assign regFileWrite     = r_regfile_write;
  assign pcEnable         = r_pc_en;
  assign pcSelectBranch   = r_pc_sel;
  assign busy             = r_busy;
  assign fault            = r_fault;
  assign retiredCount     = r_retired;

endmodule
